// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin interval timer arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   state_t        - timer FSM state encoding (IDLE, RUN, DONE)
//   DEF_NREQ       - default number of requesters
//   DEF_WIDTH      - default duration / count width
//   onehot_bit()   - helper turning an owner index into a one-hot done vector

package timer_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 32;

    // IDLE: timer free, arbitration open.
    // RUN : owner's interval counting down.
    // DONE: single expiry cycle, done pulse to the owner.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot vector of up to 32 bits with bit 'idx' set; callers keep the
    // low NREQ bits.
    function automatic logic [31:0] onehot_bit(input int unsigned idx);
        logic [31:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin picker: selects the first active request after index 'last'.
// Latency: purely combinational, zero cycles.
// Backpressure: none; 'valid' low simply means nobody is requesting.
//
// Ports:
//   req   [NREQ-1:0] - level requests
//   last  [IW-1:0]   - index of the most recent owner; its successor has top priority
//   grant [IW-1:0]   - chosen requester (0 when valid is low)
//   valid            - at least one request is active

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Walk offsets 1..NREQ from 'last'; the first hit wins. Offset NREQ is
    // 'last' itself, so the previous owner is considered only after everyone
    // else has had a chance.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (!valid && req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Interval timer shared by NREQ requesters under round-robin arbitration.
// Latency: req sampled in IDLE at edge k -> done pulse during cycle k+dur+2.
// Backpressure: losers keep req high and wait; owner dropping req aborts.
//
// Ports:
//   clk                   - single clock, all state on posedge
//   reset                 - asynchronous active-high reset
//   req   [NREQ-1:0]      - per-requester level request, held until done/abandon
//   dur   [NREQ*WIDTH-1:0]- per-requester interval, slot i at [i*WIDTH +: WIDTH]
//   done  [NREQ-1:0]      - one-cycle pulse to the owner on expiry
//   busy                  - timer owned (RUN or DONE)
//   owner [IW-1:0]        - current or most recent owner

module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [IW-1:0]         owner
);

    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic [IW-1:0]    last;

    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [WIDTH-1:0] dur_arr [NREQ];
    logic             owner_req;
    logic             count_zero;

    // Unflatten the duration bus so the grant index can select a slot directly.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dur_arr[i] = dur[i*WIDTH +: WIDTH];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .last  (last),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    assign owner_req  = req[owner];
    assign count_zero = (count == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Abandonment outranks expiry: an owner that lets go on the
                // final RUN cycle gets no done pulse.
                if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (count_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from state only, so reset clears them at once)
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
        done = '0;
        if (state == DONE) begin
            done = NREQ'(onehot_bit(int'(owner)));
        end
    end

    // ------------------------------------------------------------------
    // Datapath: count, owner, round-robin pointer
    // ------------------------------------------------------------------
    // 'last' resets to NREQ-1 so the first grant after reset starts at 0.
    // Duration is captured only at grant; later dur changes are invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            owner <= '0;
            last  <= LAST_RST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        count <= dur_arr[pick_idx];
                        owner <= pick_idx;
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        last <= owner;
                    end else if (!count_zero) begin
                        // Guarded by count_zero, so the counter never wraps.
                        count <= count - WIDTH'(1);
                    end
                end
                DONE: begin
                    last <= owner;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule
